// File: rtl/clock_pkg.sv
// Shared digit widths, limits, request-select encoding and BCD increment helper
// for the HH:MM:SS timekeeping path.
package clock_pkg;

  localparam int HRS_D_W = 2;
  localparam int MIN_D_W = 3;
  localparam int SEC_D_W = 3;
  localparam int UNIT_W  = 4;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HRS_MAX = 23;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TICK,
    SEL_HRS,
    SEL_MIN,
    SEL_SEC
  } sel_t;

  typedef struct packed {
    logic [HRS_D_W-1:0] hrs_d;
    logic [UNIT_W-1:0]  hrs_u;
    logic [MIN_D_W-1:0] min_d;
    logic [UNIT_W-1:0]  min_u;
    logic [SEC_D_W-1:0] sec_d;
    logic [UNIT_W-1:0]  sec_u;
  } bcd_time_t;

  // Two-digit BCD increment returning {tens, units}; wraps to 00 past max_val.
  function automatic logic [7:0] bcd_inc(input logic [3:0] d, input logic [3:0] u,
                                         input int unsigned max_val);
    logic [7:0] r;
    if (d == 4'(max_val / 10) && u == 4'(max_val % 10)) r = 8'd0;
    else if (u == 4'd9)                                  r = {d + 4'd1, 4'd0};
    else                                                 r = {d, u + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_next.sv
// Combinational next-time computation for one committed request (tick or adjust).
module bcd_time_next
  import clock_pkg::*;
(
  input  bcd_time_t cur,
  input  sel_t      sel,
  output bcd_time_t nxt
);

  logic [7:0] sec_inc;
  logic [7:0] min_inc;
  logic [7:0] hrs_inc;
  logic       sec_wrap;
  logic       min_wrap;

  assign sec_inc  = bcd_inc({1'b0, cur.sec_d}, cur.sec_u, SEC_MAX);
  assign min_inc  = bcd_inc({1'b0, cur.min_d}, cur.min_u, MIN_MAX);
  assign hrs_inc  = bcd_inc({2'b00, cur.hrs_d}, cur.hrs_u, HRS_MAX);
  // A legal increment is only ever zero when the field rolled over.
  assign sec_wrap = (sec_inc == 8'd0);
  assign min_wrap = (min_inc == 8'd0);

  always_comb begin
    nxt = cur;
    case (sel)
      SEL_TICK: begin
        nxt.sec_d = SEC_D_W'(sec_inc[7:4]);
        nxt.sec_u = sec_inc[3:0];
        if (sec_wrap) begin
          nxt.min_d = MIN_D_W'(min_inc[7:4]);
          nxt.min_u = min_inc[3:0];
          if (min_wrap) begin
            nxt.hrs_d = HRS_D_W'(hrs_inc[7:4]);
            nxt.hrs_u = hrs_inc[3:0];
          end
        end
      end
      SEL_HRS: begin
        nxt.hrs_d = HRS_D_W'(hrs_inc[7:4]);
        nxt.hrs_u = hrs_inc[3:0];
      end
      SEL_MIN: begin
        nxt.min_d = MIN_D_W'(min_inc[7:4]);
        nxt.min_u = min_inc[3:0];
      end
      SEL_SEC: begin
        nxt.sec_d = SEC_D_W'(sec_inc[7:4]);
        nxt.sec_u = sec_inc[3:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/time_keeper_ctrl.sv
// HH:MM:SS timekeeper: 1 Hz prescaler, pending-request capture and a fixed-priority
// arbiter committing one tick/adjust per cycle into the BCD digit registers.
module time_keeper_ctrl
  import clock_pkg::*;
#(
  parameter  int TICKS_PER_SEC = 31_500_000,
  localparam int PRESC_W       = $clog2(TICKS_PER_SEC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               adj_hrs_pulse,
  input  logic               adj_min_pulse,
  input  logic               adj_sec_pulse,
  output logic [HRS_D_W-1:0] hrs_d,
  output logic [UNIT_W-1:0]  hrs_u,
  output logic [MIN_D_W-1:0] min_d,
  output logic [UNIT_W-1:0]  min_u,
  output logic [SEC_D_W-1:0] sec_d,
  output logic [UNIT_W-1:0]  sec_u,
  output logic               sec_strobe,
  output logic               update,
  output logic               dropped
);

  typedef enum logic {IDLE, SERVICE} state_t;

  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(TICKS_PER_SEC - 1);
  localparam int REQ_TICK = 3;
  localparam int REQ_HRS  = 2;
  localparam int REQ_MIN  = 1;
  localparam int REQ_SEC  = 0;

  state_t             state, state_next;
  logic [PRESC_W-1:0] presc, presc_next;
  logic [3:0]         pend, pend_next, req, serviced;
  logic               tick_set;
  logic               drop_now;
  logic               drop_p0;
  sel_t               sel;
  bcd_time_t          cur, nxt;

  assign tick_set = run && (presc == PRESC_TC);
  assign req      = {tick_set, adj_hrs_pulse, adj_min_pulse, adj_sec_pulse};

  always_comb begin
    sel        = SEL_NONE;
    serviced   = '0;
    presc_next = presc;
    if (state == SERVICE) begin
      if (pend[REQ_TICK]) begin
        sel = SEL_TICK; serviced[REQ_TICK] = 1'b1;
      end else if (pend[REQ_HRS]) begin
        sel = SEL_HRS;  serviced[REQ_HRS] = 1'b1;
      end else if (pend[REQ_MIN]) begin
        sel = SEL_MIN;  serviced[REQ_MIN] = 1'b1;
      end else if (pend[REQ_SEC]) begin
        sel = SEL_SEC;  serviced[REQ_SEC] = 1'b1;
      end
    end
    // A request landing on its own service edge re-arms rather than coalescing.
    pend_next  = (pend & ~serviced) | req;
    drop_now   = |(req & pend & ~serviced);
    state_next = (|pend_next) ? SERVICE : IDLE;
    // A seconds adjust realigns the second boundary; tick_set still fires above.
    if (sel == SEL_SEC)  presc_next = '0;
    else if (tick_set)   presc_next = '0;
    else if (run)        presc_next = presc + PRESC_W'(1);
  end

  bcd_time_next u_next (
    .cur (cur),
    .sel (sel),
    .nxt (nxt)
  );

  // Commit stage: digits, flags and strobes all update on the service edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pend       <= '0;
      presc      <= '0;
      cur        <= '0;
      sec_strobe <= 1'b0;
      update     <= 1'b0;
      drop_p0    <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      state      <= state_next;
      pend       <= pend_next;
      presc      <= presc_next;
      cur        <= nxt;
      sec_strobe <= (sel == SEL_TICK);
      update     <= (sel != SEL_NONE);
      drop_p0    <= drop_now;
      dropped    <= drop_p0;
    end
  end

  assign hrs_d = cur.hrs_d;
  assign hrs_u = cur.hrs_u;
  assign min_d = cur.min_d;
  assign min_u = cur.min_u;
  assign sec_d = cur.sec_d;
  assign sec_u = cur.sec_u;

endmodule

// File: tb/tb_time_keeper_ctrl.sv
// Scoreboard bench for time_keeper_ctrl with a 4-cycle second.
module tb_time_keeper_ctrl;

  localparam int TPS = 4;

  logic       clk;
  logic       reset;
  logic       run;
  logic [2:0] adj_req;
  logic [1:0] hrs_d;
  logic [3:0] hrs_u;
  logic [2:0] min_d;
  logic [3:0] min_u;
  logic [2:0] sec_d;
  logic [3:0] sec_u;
  logic       sec_strobe;
  logic       update;
  logic       dropped;

  time_keeper_ctrl #(.TICKS_PER_SEC(TPS)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .adj_hrs_pulse (adj_req[2]),
    .adj_min_pulse (adj_req[1]),
    .adj_sec_pulse (adj_req[0]),
    .hrs_d         (hrs_d),
    .hrs_u         (hrs_u),
    .min_d         (min_d),
    .min_u         (min_u),
    .sec_d         (sec_d),
    .sec_u         (sec_u),
    .sec_strobe    (sec_strobe),
    .update        (update),
    .dropped       (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_strobe = 0;
  int n_upd    = 0;
  int n_drop   = 0;

  logic [22:0] exp_q[$];

  // Reference model state: plain integers, advanced once per active edge.
  int m_h = 0, m_m = 0, m_s = 0, m_presc = 0, m_sel = 0;
  bit pt = 0, ph = 0, pm = 0, ps = 0, m_drop_prev = 0, m_tc = 0, m_dn = 0;

  function automatic logic [19:0] tpack(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [19:0] obs_time();
    return {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u};
  endfunction

  function automatic logic [22:0] obs_all();
    return {obs_time(), sec_strobe, update, dropped};
  endfunction

  function automatic logic in_range();
    return (hrs_d <= 2) && (hrs_u <= 9) && !(hrs_d == 2 && hrs_u > 3) &&
           (min_d <= 5) && (min_u <= 9) && (sec_d <= 5) && (sec_u <= 9);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_h = 0; m_m = 0; m_s = 0; m_presc = 0;
      pt = 0; ph = 0; pm = 0; ps = 0; m_drop_prev = 0;
      exp_q.delete();
    end else begin
      m_sel = 0;
      if (pt) m_sel = 1; else if (ph) m_sel = 2; else if (pm) m_sel = 3; else if (ps) m_sel = 4;
      case (m_sel)
        1: begin
          m_s++;
          if (m_s == 60) begin
            m_s = 0; m_m++;
            if (m_m == 60) begin m_m = 0; m_h = (m_h + 1) % 24; end
          end
        end
        2: m_h = (m_h + 1) % 24;
        3: m_m = (m_m + 1) % 60;
        4: m_s = (m_s + 1) % 60;
        default: ;
      endcase
      m_tc = run && (m_presc == TPS - 1);
      if (m_sel == 4) m_presc = 0;
      else if (run)   m_presc = m_tc ? 0 : m_presc + 1;
      m_dn = (m_tc && pt && m_sel != 1) || (adj_req[2] && ph && m_sel != 2) ||
             (adj_req[1] && pm && m_sel != 3) || (adj_req[0] && ps && m_sel != 4);
      if (m_sel == 1) pt = 0;
      if (m_sel == 2) ph = 0;
      if (m_sel == 3) pm = 0;
      if (m_sel == 4) ps = 0;
      pt = pt | m_tc; ph = ph | adj_req[2]; pm = pm | adj_req[1]; ps = ps | adj_req[0];
      exp_q.push_back({tpack(m_h, m_m, m_s), 1'(m_sel == 1), 1'(m_sel != 0), m_drop_prev});
      m_drop_prev = m_dn;
    end
  end

  task automatic step(input int n);
    logic [22:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!reset) begin
        n_strobe += int'(sec_strobe);
        n_upd    += int'(update);
        n_drop   += int'(dropped);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_val("cycle", 32'(obs_all()), 32'(e));
          check_val("range", 32'(in_range()), 32'd1);
        end
      end
    end
  endtask

  task automatic pulse_n(input int idx, input int n);
    if (n > 0) begin
      adj_req[idx] = 1'b1;
      step(n);
      adj_req[idx] = 1'b0;
      step(2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_s, base_u, base_d, hb, mb, sb;
    bit got;
    reset = 1'b1; run = 1'b0; adj_req = 3'b000;
    repeat (3) @(negedge clk);
    check_val("reset_state", 32'(obs_all()), 32'd0);
    reset = 1'b0;
    run   = 1'b1;

    // Free run: ten seconds.
    base_s = n_strobe; base_u = n_upd;
    step(41);
    check_val("run_strobes", n_strobe - base_s, 10);
    check_val("run_updates", n_upd - base_u, 10);
    check_val("run_time", 32'(obs_time()), 32'(tpack(0, 0, 10)));

    // Preload 23:59:59 and let one tick roll everything over.
    run = 1'b0;
    step(2);
    pulse_n(2, 23 - m_h);
    pulse_n(1, 59 - m_m);
    pulse_n(0, 59 - m_s);
    check_val("preload", 32'(obs_time()), 32'(tpack(23, 59, 59)));
    run = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1);
      if (sec_strobe) got = 1'b1;
    end
    check_val("tick_wait", 32'(got), 32'd1);
    check_val("day_wrap", 32'(obs_time()), 32'(tpack(0, 0, 0)));
    run = 1'b0;
    step(2);

    // All three adjusts on the terminal-count edge.
    pulse_n(0, 1);
    run = 1'b1;
    step(3);
    base_d = n_drop;
    adj_req = 3'b111;
    step(1);
    adj_req = 3'b000;
    step(1);
    check_val("arb_tick_strobe", 32'(sec_strobe), 32'd1);
    check_val("arb_tick_upd", 32'(update), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(1);
      check_val("arb_adj_upd", 32'(update), 32'd1);
      check_val("arb_adj_nostrobe", 32'(sec_strobe), 32'd0);
    end
    run = 1'b0;
    step(3);
    check_val("arb_no_drop", n_drop - base_d, 0);

    // Minute and hour adjusts wrap without carrying.
    pulse_n(1, 59 - m_m);
    hb = m_h;
    pulse_n(1, 1);
    check_val("min_wrap", 32'({min_d, min_u, hrs_d, hrs_u}),
              32'({3'(0), 4'(0), 2'(hb / 10), 4'(hb % 10)}));
    pulse_n(2, 23 - m_h);
    check_val("hrs_23", 32'({hrs_d, hrs_u}), 32'({2'd2, 4'd3}));
    mb = m_m; sb = m_s;
    pulse_n(2, 1);
    check_val("hrs_wrap", 32'(obs_time()), 32'(tpack(0, mb, sb)));

    // Second sec request behind a pending tick coalesces.
    pulse_n(0, 1);
    run = 1'b1;
    step(3);
    sb = m_s;
    base_d = n_drop;
    adj_req[0] = 1'b1;
    step(2);
    adj_req[0] = 1'b0;
    run = 1'b0;
    step(4);
    check_val("coalesce_drop", n_drop - base_d, 1);
    check_val("coalesce_sec", 32'({sec_d, sec_u}), 32'({3'((sb + 2) % 60 / 10), 4'((sb + 2) % 60 % 10)}));

    // Held prescaler, five spaced second adjusts.
    pulse_n(0, (60 - m_s) % 60);
    step(20);
    for (int k = 0; k < 5; k++) begin
      adj_req[0] = 1'b1;
      step(1);
      adj_req[0] = 1'b0;
      step(2);
    end
    check_val("sec_five", 32'({sec_d, sec_u}), 32'({3'd0, 4'd5}));

    // Asynchronous reset in the middle of servicing.
    adj_req = 3'b111;
    step(1);
    adj_req = 3'b000;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_val("async_reset", 32'(obs_all()), 32'd0);
    step(2);
    reset = 1'b0;
    base_s = n_strobe; base_u = n_upd;
    step(10);
    check_val("post_reset_strobe", n_strobe - base_s, 0);
    check_val("post_reset_upd", n_upd - base_u, 0);
    check_val("post_reset_time", 32'(obs_time()), 32'(tpack(0, 0, 0)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
